regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core's decode stage.
- Provides NUM_RD synchronous read ports and two write ports (ALU writeback, load writeback), with write-through bypass on every read port.
- Keeps a per-register pending scoreboard for hazard detection.
- Adds a sequential bulk-clear engine, so the core can flush the integer or floating bank (lower/upper halves) without asserting global reset.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, minimum 4.
- AW, 5, address width; must equal log2(DEPTH).
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  packed registered read data; port k occupies bits [k*DW +: DW].
- rd_pend  out  NUM_RD  scoreboard pending bit of each read address, registered alongside rd_data.
- we0  in  1  write enable, port 0 (ALU).
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (load); wins over port 0.
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- claim  in  1  set the pending bit of claim_addr.
- claim_addr  in  AW  destination register being issued.
- clr_req  in  1  start a bank clear.
- clr_bank  in  1  bank select: 0 = registers 0..DEPTH/2-1, 1 = registers DEPTH/2..DEPTH-1.
- clr_busy  out  1  high while a clear sweep runs.

Behaviour:
- Reset (async, immediate): all registers 0, all pending bits 0, rd_data 0, rd_pend 0, clr_busy 0, FSM in IDLE, sweep counter 0.
- Read latency is 1 cycle. rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N.
- Read value priority, highest first:
  - ZERO_REG and address 0 gives 0.
  - Port 1 write to the same address this cycle gives wd1.
  - Port 0 write to the same address this cycle gives wd0.
  - Otherwise the array contents.
- Write rules:
  - A port writes when its we is high and the address is not 0 (when ZERO_REG=1).
  - If both ports target the same address, wd1 is stored and wd0 is dropped.
  - Writes to different addresses both commit in the same cycle.
- Scoreboard:
  - claim sets pending[claim_addr].
  - An enabled write clears pending[wa].
  - If claim and a write hit the same address in the same cycle, claim wins and the bit is set (the new producer is in flight).
  - Address 0 is never pending when ZERO_REG=1.
  - rd_pend[k] uses post-update semantics: it shows the bit value after this edge's set/clear.
- Clear FSM, IDLE -> SWEEP -> IDLE:
  - IDLE: clr_req=1 latches clr_bank, loads the counter with the bank base (0 or DEPTH/2), goes to SWEEP, and sets clr_busy=1 on the same edge.
  - SWEEP: each cycle writes 0 to register[counter], clears its pending bit, and increments the counter.
  - After the last register of the bank is cleared, returns to IDLE with clr_busy=0. The sweep takes exactly DEPTH/2 cycles.
  - clr_req during SWEEP is ignored; there is no queueing.
- During SWEEP:
  - we0, we1 and claim to addresses inside the selected bank are dropped.
  - Accesses outside the bank proceed normally.
  - Reads of in-bank addresses return 0 and rd_pend 0.
- Reset asserted mid-sweep aborts immediately to the reset state above.
- Out-of-range addresses cannot occur, since DEPTH = 2^AW.

Test Plan:
- Reset then read: assert rst, release, read addresses 0..31 on both ports -> every rd_data = 0x00000000 and rd_pend = 0.
- Write/read and bypass: we0 wa0=5 wd0=0xDEADBEEF, with rd_addr port0=5 in the same cycle -> next cycle rd_data0 = 0xDEADBEEF; one cycle later (no write) it still reads 0xDEADBEEF from the array.
- Dual-write conflict: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 in the same cycle -> read of 7 = 0x22. Then we0 wa0=3 wd0=0xA and we1 wa1=4 wd1=0xB -> reg3 = 0xA, reg4 = 0xB.
- Zero register: we1 wa1=0 wd1=0xFFFFFFFF, and claim claim_addr=0 -> read 0 = 0, rd_pend = 0.
- Scoreboard: claim 9 -> rd_pend for 9 = 1. Then claim 9 together with we0 wa0=9 -> stays 1. Then we0 wa0=9 alone -> 0.
- Bank clear: write 0x55 to regs 2 and 20, clr_req clr_bank=1 -> clr_busy high for exactly 16 cycles; a write to 25 mid-sweep is dropped; afterwards reg20 = 0, reg25 = 0, reg2 = 0x55. Repeat with rst asserted at sweep cycle 5 -> all outputs 0 immediately and clr_busy = 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with write-through bypass, pending
//            scoreboard and a sequential half-bank clear engine.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_pend,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [DW-1:0]        wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [DW-1:0]        wd1,
  input  logic                 claim,
  input  logic [AW-1:0]        claim_addr,
  input  logic                 clr_req,
  input  logic                 clr_bank,
  output logic                 clr_busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;
  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_bank;
  logic             r_busy;

  logic w_sweep;
  logic w_ok0;
  logic w_ok1;
  logic w_okc;

  assign w_sweep  = (r_state == ST_SWEEP);
  assign clr_busy = r_busy;

  // A request is dropped when it targets the hardwired zero register or the bank being swept.
  assign w_ok0 = we0 && !((ZERO_REG != 0) && (wa0 == '0)) &&
                 !(w_sweep && (wa0[AW-1] == r_bank));
  assign w_ok1 = we1 && !((ZERO_REG != 0) && (wa1 == '0)) &&
                 !(w_sweep && (wa1[AW-1] == r_bank));
  assign w_okc = claim && !((ZERO_REG != 0) && (claim_addr == '0)) &&
                 !(w_sweep && (claim_addr[AW-1] == r_bank));

  // Claim is applied after the write clears so a new producer stays pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_ok0) w_pend_nxt[wa0] = 1'b0;
    if (w_ok1) w_pend_nxt[wa1] = 1'b0;
    if (w_okc) w_pend_nxt[claim_addr] = 1'b1;
    if (w_sweep) w_pend_nxt[r_cnt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_ok0 && !(w_ok1 && (wa1 == wa0))) r_mem[wa0] <= wd0;
      if (w_ok1) r_mem[wa1] <= wd1;
      if (w_sweep) r_mem[r_cnt] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bank  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_bank  <= clr_bank;
            r_cnt   <= {clr_bank, {(AW-1){1'b0}}};
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt[AW-2:0]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_val;
    logic          w_pnd;
    logic [DW-1:0] r_data;
    logic          r_pnd;

    assign w_a = rd_addr[k*AW +: AW];

    always_comb begin
      w_val = r_mem[w_a];
      w_pnd = w_pend_nxt[w_a];
      if (((ZERO_REG != 0) && (w_a == '0)) || (w_sweep && (w_a[AW-1] == r_bank))) begin
        w_val = '0;
        w_pnd = 1'b0;
      end else if (w_ok1 && (wa1 == w_a)) begin
        w_val = wd1;
      end else if (w_ok0 && (wa0 == w_a)) begin
        w_val = wd0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
        r_pnd  <= 1'b0;
      end else begin
        r_data <= w_val;
        r_pnd  <= w_pnd;
      end
    end

    assign rd_data[k*DW +: DW] = r_data;
    assign rd_pend[k]          = r_pnd;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Randomised and directed checks of regfile_mp against a reference model.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic        we0 = 1'b0, we1 = 1'b0, claim = 1'b0, clr_req = 1'b0, clr_bank = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, claim_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        clr_busy;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .claim(claim), .claim_addr(claim_addr), .clr_req(clr_req), .clr_bank(clr_bank),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: register contents, pending flags, remaining sweep cycles.
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  int          m_left, m_idx;
  bit          m_bank;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
    m_idx  = 0;
    m_bank = 1'b0;
  endtask

  function automatic bit inb(input int a);
    return (m_left > 0) && ((a >= 16) == m_bank);
  endfunction

  task automatic idle_inputs();
    we0 = 0; we1 = 0; claim = 0; clr_req = 0;
  endtask

  // One clock: predict outputs from the model, advance it, then compare.
  task automatic step();
    logic [31:0] ev [2];
    bit          ep [2];
    bit          np [32];
    bit          ok0, ok1, okc;
    int          a;
    ok0 = we0 && wa0 != 0 && !inb(int'(wa0));
    ok1 = we1 && wa1 != 0 && !inb(int'(wa1));
    okc = claim && claim_addr != 0 && !inb(int'(claim_addr));
    np = m_pend;
    if (ok0) np[wa0] = 1'b0;
    if (ok1) np[wa1] = 1'b0;
    if (okc) np[claim_addr] = 1'b1;
    if (m_left > 0) np[m_idx] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = int'(rd_addr[k*5 +: 5]);
      if (a == 0 || inb(a)) begin
        ev[k] = '0;
        ep[k] = 1'b0;
      end else begin
        if (ok1 && wa1 == a)      ev[k] = wd1;
        else if (ok0 && wa0 == a) ev[k] = wd0;
        else                      ev[k] = m_mem[a];
        ep[k] = np[a];
      end
    end
    if (ok0) m_mem[wa0] = wd0;
    if (ok1) m_mem[wa1] = wd1;
    if (m_left > 0) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_left--;
    end else if (clr_req) begin
      m_bank = clr_bank;
      m_idx  = clr_bank ? 16 : 0;
      m_left = 16;
    end
    m_pend = np;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_data%0d", k), 64'(rd_data[k*32 +: 32]), 64'(ev[k]));
      check($sformatf("rd_pend%0d", k), 64'(rd_pend[k]), 64'(ep[k]));
    end
    check("clr_busy", 64'(clr_busy), 64'(m_left > 0));
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr[4:0] = 5'(a0);
    rd_addr[9:5] = 5'(a1);
  endtask

  int busy_cnt;

  initial begin
    m_reset();
    #1;
    check("reset_data", rd_data, 64'h0);
    check("reset_pend", 64'(rd_pend), 64'h0);
    check("reset_busy", 64'(clr_busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd(i, 31 - i);
      step();
      check("init_read", rd_data, 64'h0);
    end

    // write with same-cycle bypass, then from the array
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; rd(5, 0);
    step();
    check("bypass0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    idle_inputs();
    step();
    check("array5", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // dual write conflict, then disjoint writes
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    step();
    we0 = 1; wa0 = 3; wd0 = 32'hA; we1 = 1; wa1 = 4; wd1 = 32'hB; rd(7, 0);
    step();
    check("conflict7", 64'(rd_data[31:0]), 64'h22);
    idle_inputs(); rd(3, 4);
    step();
    check("reg3", 64'(rd_data[31:0]), 64'hA);
    check("reg4", 64'(rd_data[63:32]), 64'hB);

    // zero register
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; claim = 1; claim_addr = 0; rd(0, 0);
    step();
    idle_inputs();
    step();
    check("zero_data", 64'(rd_data[31:0]), 64'h0);
    check("zero_pend", 64'(rd_pend[0]), 64'h0);

    // scoreboard
    claim = 1; claim_addr = 9; rd(9, 9);
    step();
    check("claim9", 64'(rd_pend[0]), 64'h1);
    we0 = 1; wa0 = 9; wd0 = 32'h1234;
    step();
    check("claim_wins", 64'(rd_pend[1]), 64'h1);
    claim = 0;
    step();
    check("write_clears", 64'(rd_pend[0]), 64'h0);
    idle_inputs();

    // bank clear with a dropped in-bank write
    we0 = 1; wa0 = 2; wd0 = 32'h55; we1 = 1; wa1 = 20; wd1 = 32'h55;
    step();
    idle_inputs();
    clr_req = 1; clr_bank = 1;
    step();
    clr_req = 0;
    busy_cnt = 0;
    while (clr_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 5) begin
        we0 = 1; wa0 = 25; wd0 = 32'h99; rd(25, 2);
      end
      step();
      we0 = 0;
    end
    check("busy_len", 64'(busy_cnt), 64'd16);
    rd(20, 25);
    step();
    check("reg20_clr", 64'(rd_data[31:0]), 64'h0);
    check("reg25_drop", 64'(rd_data[63:32]), 64'h0);
    rd(2, 0);
    step();
    check("reg2_kept", 64'(rd_data[31:0]), 64'h55);

    // reset in the middle of a sweep
    we0 = 1; wa0 = 6; wd0 = 32'h77; claim = 1; claim_addr = 8;
    step();
    idle_inputs();
    clr_req = 1; clr_bank = 0; rd(6, 8);
    step();
    clr_req = 0;
    for (int i = 0; i < 4; i++) step();
    #2 rst = 1'b1;
    #1;
    check("abort_data", rd_data, 64'h0);
    check("abort_pend", 64'(rd_pend), 64'h0);
    check("abort_busy", 64'(clr_busy), 64'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    rd(2, 6);
    step();
    check("after_abort", rd_data, 64'h0);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      we0 = ($urandom_range(0, 2) != 0); wa0 = 5'($urandom); wd0 = $urandom;
      we1 = ($urandom_range(0, 2) == 0); wa1 = 5'($urandom); wd1 = $urandom;
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      claim = ($urandom_range(0, 2) == 0); claim_addr = 5'($urandom);
      if ($urandom_range(0, 4) == 0) claim_addr = wa0;
      clr_req = ($urandom_range(0, 39) == 0); clr_bank = 1'($urandom);
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wa1;
      step();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
